dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Data-memory responder serving the load/store requests issued by MEM_stage of the 5-stage RV32I pipeline. It accepts one request per handshake and applies RV32I byte/half/word lane rules on the stored word. It returns load data or a store acknowledgement after a configurable number of wait states. It flags misaligned, illegal and out-of-range accesses with an error response, and for those accesses it does not modify the array.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; must be ≥2.
WAIT_STATES, 1, extra cycles between accept and response; 0..15.
ADDR_BASE, 32'h0000_0000, byte address of word 0; must be word aligned.

Ports:
clk  input  1  clock, all logic on rising edge
rst_  input  1  synchronous reset, active-high (1 = reset)
req_valid  input  1  request present
req_ready  output  1  responder can accept this cycle
req_write  input  1  1 = store, 0 = load
req_addr  input  32  byte address (MEM alu_result)
req_wdata  input  32  store data, right-aligned (rs2)
req_funct3  input  3  RV32I load/store funct3
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  access rejected; qualified by rsp_valid

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset (rst_=1 at clk edge): state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, request latches=0. Array contents are not cleared. req_ready=0 while rst_=1.
- req_ready = !rst_ && (state==IDLE || state==RESP).
- Accept: req_valid && req_ready at an edge latches write, addr, wdata and funct3. Next state is WAIT if WAIT_STATES>0, otherwise RESP.
- WAIT: count 1..WAIT_STATES, then RESP. req_valid is ignored because req_ready=0.
- Latency: rsp_valid is high exactly WAIT_STATES+1 cycles after the accept edge. With WAIT_STATES=1, a request accepted at edge N is answered at edge N+2.
- RESP lasts one cycle with rsp_valid=1. If a new request is accepted in that same cycle, go to WAIT or RESP as above. Otherwise go to IDLE. Full throughput at WAIT_STATES=0 is 1 request per cycle.
- Commit: the array read or write happens on the edge that enters RESP. The load result is registered into rsp_rdata on that edge.
- Word index = (addr - ADDR_BASE) >> 2. Byte offset = addr[1:0].
- Error, checked in priority order; any error sets rsp_err=1, rsp_rdata=0, no array write:
  1. Illegal funct3. Loads: 011, 110, 111. Stores: any value other than 000/001/010.
  2. Misaligned. Half with addr[0]=1. Word with addr[1:0]≠0.
  3. Out of range. addr<ADDR_BASE, or word index ≥ DEPTH_WORDS.
- Stores: SB writes byte lane addr[1:0] with wdata[7:0]. SH writes lanes {addr[1],0}+1:{addr[1],0} with wdata[15:0]. SW writes all lanes. Other lanes are unchanged. rsp_rdata=0, rsp_err=0.
- Loads: the selected lane is right-shifted. LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word.
- Reset mid-operation (in WAIT, or in the accept cycle): the request is dropped, no write is committed, and no rsp_valid is produced.
- rsp_valid and rsp_err are low in every non-RESP cycle. rsp_rdata holds its last value outside RESP.

Decomposition:
- Shared package rv32_mem_pkg holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - the state encoding typedef (IDLE/WAIT/RESP);
  - the lane-select helper constants.
- One combinational sub-module, dmem_lane_align, provides:
  - store merge: old word, wdata, funct3 and offset in; new word and legality out;
  - load extract/extend: word, funct3 and offset in; rdata and legality out.
- The FSM, counter and array stay in dmem_responder.

Test Plan:
- Reset, then SW 0xDEADBEEF @0x10 → rsp_valid exactly 2 cycles after accept, rsp_err=0, rsp_rdata=0. Then LW @0x10 → rsp_rdata=0xDEADBEEF.
- SB wdata=0x000000A5 @0x13, then:
  - LW @0x10 → 0xA5ADBEEF;
  - LB @0x13 → 0xFFFFFFA5;
  - LBU @0x13 → 0x000000A5;
  - LH @0x12 → 0xFFFFA5AD;
  - LHU @0x12 → 0x0000A5AD.
- Errors, each giving rsp_err=1 and rsp_rdata=0:
  - LH @0x11;
  - SW @0x12 followed by LW @0x10 → 0xA5ADBEEF unchanged;
  - LW @0x1000 with DEPTH_WORDS=1024;
  - load with funct3=011.
- Back-to-back: hold req_valid high for 3 LWs. req_ready is low during WAIT and high in the RESP cycles; responses arrive in order, one per 2 cycles with WAIT_STATES=1, none lost or duplicated.
- Reset mid-op: accept SW 0x11111111 @0x20 and assert rst_ in the WAIT cycle → no rsp_valid. A later LW @0x20 returns the prior contents.
- WAIT_STATES=0 build: SW then LW issued on consecutive cycles → responses on consecutive cycles. The LW returns the just-stored value.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv32_mem_pkg
// Brief   : Shared RV32I load/store constants, responder state encoding and
//           lane-select helpers.
// Revision: 1.0 - initial release
// ============================================================================
package rv32_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] c_byte_mask = 32'h0000_00FF;
    localparam logic [31:0] c_half_mask = 32'h0000_FFFF;

    // Bit distance of a byte lane from bit 0 of the word.
    function automatic logic [4:0] lane_shift(input logic [1:0] offset);
        return {offset, 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : dmem_lane_align
// Brief   : Combinational RV32I byte/half/word store merge and load
//           extract/extend, each with a legality flag.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_lane_align
    import rv32_mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    output logic [31:0] o_store_word,
    output logic        o_store_ok,
    output logic [31:0] o_load_data,
    output logic        o_load_ok
);

    logic [4:0]  w_shift;
    logic [31:0] w_lane_mask;
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_shift = lane_shift(i_offset);
    assign w_half  = i_offset[1] ? i_word[31:16] : i_word[15:0];
    assign w_byte  = i_offset[0] ? w_half[15:8]  : w_half[7:0];

    always_comb begin
        o_store_ok  = 1'b0;
        w_lane_mask = '0;
        case (i_funct3)
            F3_B: begin
                o_store_ok  = 1'b1;
                w_lane_mask = c_byte_mask << w_shift;
            end
            F3_H: begin
                o_store_ok  = !i_offset[0];
                w_lane_mask = c_half_mask << w_shift;
            end
            F3_W: begin
                o_store_ok  = (i_offset == 2'b00);
                w_lane_mask = '1;
            end
            default: ;
        endcase
    end

    assign o_store_word = (i_word & ~w_lane_mask) | ((i_wdata << w_shift) & w_lane_mask);

    always_comb begin
        o_load_ok   = 1'b0;
        o_load_data = '0;
        case (i_funct3)
            F3_B: begin
                o_load_ok   = 1'b1;
                o_load_data = {{24{w_byte[7]}}, w_byte};
            end
            F3_BU: begin
                o_load_ok   = 1'b1;
                o_load_data = {24'h0, w_byte};
            end
            F3_H: begin
                o_load_ok   = !i_offset[0];
                o_load_data = {{16{w_half[15]}}, w_half};
            end
            F3_HU: begin
                o_load_ok   = !i_offset[0];
                o_load_data = {16'h0, w_half};
            end
            F3_W: begin
                o_load_ok   = (i_offset == 2'b00);
                o_load_data = i_word;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder
// Brief   : RV32I data-memory responder: one request per handshake, fixed
//           wait states, byte/half/word lanes and error responses.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_responder
    import rv32_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
)(
    input  logic        clk,
    input  logic        rst_,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] c_depth     = 32'(DEPTH_WORDS);
    localparam logic [3:0]  c_wait_last = 4'(WAIT_STATES);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_wait_cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept;
    logic        w_commit;
    logic        w_wait_done;
    logic        w_c_write;
    logic [31:0] w_c_addr;
    logic [31:0] w_c_wdata;
    logic [2:0]  w_c_funct3;
    logic [31:0] w_rel_addr;
    logic        w_in_range;
    logic [IDX_W-1:0] w_idx;
    logic [31:0] w_mem_word;
    logic [31:0] w_store_word;
    logic [31:0] w_load_data;
    logic        w_store_ok;
    logic        w_load_ok;
    logic        w_err;

    assign req_ready   = !rst_ && (r_state == IDLE || r_state == RESP);
    assign w_accept    = req_valid && req_ready;
    assign w_wait_done = (r_wait_cnt == c_wait_last);

    always_ff @(posedge clk) begin
        if (rst_) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        case (r_state)
            IDLE, RESP: begin
                if (w_accept) begin
                    if (WAIT_STATES == 0) begin
                        w_state_next = RESP;
                        w_commit     = 1'b1;
                    end else begin
                        w_state_next = WAIT;
                    end
                end else begin
                    w_state_next = IDLE;
                end
            end
            WAIT: begin
                if (w_wait_done) begin
                    w_state_next = RESP;
                    w_commit     = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The first WAIT cycle is count 1, so count==WAIT_STATES marks the last one.
    always_ff @(posedge clk) begin
        if (rst_) begin
            r_wait_cnt <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_funct3   <= '0;
        end else begin
            if (w_accept) begin
                r_wait_cnt <= 4'd1;
                r_write    <= req_write;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_funct3   <= req_funct3;
            end else if (r_state == WAIT) begin
                r_wait_cnt <= w_wait_done ? 4'd0 : r_wait_cnt + 4'd1;
            end
        end
    end

    // With no wait states the commit edge is the accept edge itself.
    assign w_c_write  = (WAIT_STATES == 0) ? req_write  : r_write;
    assign w_c_addr   = (WAIT_STATES == 0) ? req_addr   : r_addr;
    assign w_c_wdata  = (WAIT_STATES == 0) ? req_wdata  : r_wdata;
    assign w_c_funct3 = (WAIT_STATES == 0) ? req_funct3 : r_funct3;

    assign w_rel_addr = w_c_addr - ADDR_BASE;
    assign w_in_range = (w_c_addr >= ADDR_BASE) && ({2'b00, w_rel_addr[31:2]} < c_depth);
    assign w_idx      = w_rel_addr[IDX_W+1:2];
    assign w_mem_word = r_mem[w_idx];

    dmem_lane_align u_lane_align (
        .i_word       (w_mem_word),
        .i_wdata      (w_c_wdata),
        .i_funct3     (w_c_funct3),
        .i_offset     (w_rel_addr[1:0]),
        .o_store_word (w_store_word),
        .o_store_ok   (w_store_ok),
        .o_load_data  (w_load_data),
        .o_load_ok    (w_load_ok)
    );

    assign w_err = !(w_c_write ? w_store_ok : w_load_ok) || !w_in_range;

    always_ff @(posedge clk) begin
        if (!rst_ && w_commit && w_c_write && !w_err) r_mem[w_idx] <= w_store_word;
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_commit;
            r_rsp_err   <= w_commit && w_err;
            if (w_commit) r_rsp_rdata <= (w_c_write || w_err) ? 32'h0 : w_load_data;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_responder
// Brief   : Directed self-checking bench for dmem_responder (one-wait-state
//           instance plus a zero-wait-state, offset-base instance).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_responder;
    import rv32_mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_;
    logic        req_valid, req_write, req_ready, rsp_valid, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [2:0]  req_funct3;

    logic        z_valid, z_write, z_ready, z_rsp_valid, z_rsp_err;
    logic [31:0] z_addr, z_wdata, z_rsp_rdata;
    logic [2:0]  z_funct3;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .ADDR_BASE(32'h0)) dut (
        .clk(clk), .rst_(rst_),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0), .ADDR_BASE(32'h100)) dut0 (
        .clk(clk), .rst_(rst_),
        .req_valid(z_valid), .req_ready(z_ready), .req_write(z_write),
        .req_addr(z_addr), .req_wdata(z_wdata), .req_funct3(z_funct3),
        .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    // One transaction on the WAIT_STATES=1 instance; lat counts cycles from accept.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, output int lat, output logic [31:0] rdata,
                         output logic err);
        int guard;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) lat = -1;
        rdata = rsp_rdata;
        err   = rsp_err;
    endtask

    task automatic drive0(input logic v, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3);
        z_valid = v; z_write = wr; z_addr = addr; z_wdata = wdata; z_funct3 = f3;
    endtask

    task automatic test_reset();
        rst_ = 1'b1;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_funct3 = 0;
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
        repeat (3) @(negedge clk);
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        n_checks++; if (z_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_ws0: got %b want 0", z_ready); end
        rst_ = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_store_word();
        int lat; logic [31:0] rd; logic er;
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, F3_W, lat, rd, er);
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL sw_latency: got %0d want 2", lat); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL sw_err: got %b want 0", er); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL sw_rdata: got %h want 0", rd); end
        issue(1'b0, 32'h10, 32'h0, F3_W, lat, rd, er);
        n_checks++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat != 2)
            begin n_fail++; $display("FAIL lw_after_sw: got %h err %b lat %0d want deadbeef 0 2", rd, er, lat); end
    endtask

    task automatic test_byte_lanes();
        int lat; logic [31:0] rd; logic er;
        logic [2:0]  f3s  [5] = '{F3_W, F3_B, F3_BU, F3_H, F3_HU};
        logic [31:0] adrs [5] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h12};
        logic [31:0] exps [5] = '{32'hA5AD_BEEF, 32'hFFFF_FFA5, 32'h0000_00A5, 32'hFFFF_A5AD, 32'h0000_A5AD};
        issue(1'b1, 32'h13, 32'h0000_00A5, F3_B, lat, rd, er);
        n_checks++; if (er !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL sb_rsp: got %h err %b want 0 0", rd, er); end
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, adrs[i], 32'h0, f3s[i], lat, rd, er);
            n_checks++;
            if (rd !== exps[i] || er !== 1'b0)
                begin n_fail++; $display("FAIL load_lane_%0d: got %h err %b want %h 0", i, rd, er, exps[i]); end
        end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic er;
        logic        wrs  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] adrs [5] = '{32'h11, 32'h12, 32'h1000, 32'h10, 32'h10};
        logic [2:0]  f3s  [5] = '{F3_H, F3_W, F3_W, 3'b011, 3'b100};
        for (int i = 0; i < 5; i++) begin
            issue(wrs[i], adrs[i], 32'h1234_5678, f3s[i], lat, rd, er);
            n_checks++;
            if (er !== 1'b1 || rd !== 32'h0 || lat != 2)
                begin n_fail++; $display("FAIL error_case_%0d: got %h err %b lat %0d want 0 1 2", i, rd, er, lat); end
        end
        issue(1'b0, 32'h10, 32'h0, F3_W, lat, rd, er);
        n_checks++; if (rd !== 32'hA5AD_BEEF || er !== 1'b0)
            begin n_fail++; $display("FAIL unchanged_after_err: got %h err %b want a5adbeef 0", rd, er); end
        issue(1'b0, 32'hFFC, 32'h0, F3_W, lat, rd, er);
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL last_word_in_range: got err %b want 0", er); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic er;
        int sent, nr;
        logic [31:0] vals [3] = '{32'h0BAD_0040, 32'h0BAD_0044, 32'h0BAD_0048};
        logic [7:0] exp_ready = 8'b1101_0101;
        logic [7:0] exp_rv    = 8'b0101_0100;
        for (int i = 0; i < 3; i++) issue(1'b1, 32'h40 + 32'(i * 4), vals[i], F3_W, lat, rd, er);
        sent = 0; nr = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_checks++; if (req_ready !== exp_ready[k])
                begin n_fail++; $display("FAIL b2b_ready_c%0d: got %b want %b", k, req_ready, exp_ready[k]); end
            n_checks++; if (rsp_valid !== exp_rv[k])
                begin n_fail++; $display("FAIL b2b_rsp_valid_c%0d: got %b want %b", k, rsp_valid, exp_rv[k]); end
            if (rsp_valid === 1'b1) begin
                if (nr < 3) begin
                    n_checks++; if (rsp_rdata !== vals[nr])
                        begin n_fail++; $display("FAIL b2b_rdata_%0d: got %h want %h", nr, rsp_rdata, vals[nr]); end
                end
                nr++;
            end
            if (sent < 3) begin
                req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h40 + 32'(sent * 4);
                if (req_ready) sent++;
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        n_checks++; if (nr != 3) begin n_fail++; $display("FAIL b2b_rsp_count: got %0d want 3", nr); end
    endtask

    task automatic test_reset_midop();
        int lat; logic [31:0] rd; logic er;
        issue(1'b1, 32'h20, 32'h5A5A_5A5A, F3_W, lat, rd, er);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1111_1111; req_funct3 = F3_W;
        @(negedge clk);
        req_valid = 1'b0; rst_ = 1'b1;
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL midop_ready_in_reset: got %b want 0", req_ready); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rst_ = 1'b0;
            n_checks++; if (rsp_valid !== 1'b0)
                begin n_fail++; $display("FAIL midop_no_rsp_c%0d: got %b want 0", k, rsp_valid); end
        end
        issue(1'b0, 32'h20, 32'h0, F3_W, lat, rd, er);
        n_checks++; if (rd !== 32'h5A5A_5A5A || er !== 1'b0)
            begin n_fail++; $display("FAIL midop_prior_contents: got %h err %b want 5a5a5a5a 0", rd, er); end
    endtask

    task automatic test_ws0();
        @(negedge clk);
        drive0(1'b1, 1'b1, 32'h130, 32'hCAFE_F00D, F3_W);
        @(negedge clk);
        n_checks++; if (z_rsp_valid !== 1'b1 || z_rsp_err !== 1'b0 || z_rsp_rdata !== 32'h0)
            begin n_fail++; $display("FAIL ws0_sw: got v%b e%b %h want v1 e0 0", z_rsp_valid, z_rsp_err, z_rsp_rdata); end
        n_checks++; if (z_ready !== 1'b1) begin n_fail++; $display("FAIL ws0_ready_in_resp: got %b want 1", z_ready); end
        drive0(1'b1, 1'b0, 32'h130, 32'h0, F3_W);
        @(negedge clk);
        n_checks++; if (z_rsp_valid !== 1'b1 || z_rsp_rdata !== 32'hCAFE_F00D || z_rsp_err !== 1'b0)
            begin n_fail++; $display("FAIL ws0_lw: got v%b e%b %h want v1 e0 cafef00d", z_rsp_valid, z_rsp_err, z_rsp_rdata); end
        drive0(1'b1, 1'b0, 32'h0FC, 32'h0, F3_W);
        @(negedge clk);
        n_checks++; if (z_rsp_valid !== 1'b1 || z_rsp_err !== 1'b1 || z_rsp_rdata !== 32'h0)
            begin n_fail++; $display("FAIL ws0_below_base: got v%b e%b %h want v1 e1 0", z_rsp_valid, z_rsp_err, z_rsp_rdata); end
        drive0(1'b1, 1'b0, 32'h140, 32'h0, F3_W);
        @(negedge clk);
        n_checks++; if (z_rsp_valid !== 1'b1 || z_rsp_err !== 1'b1)
            begin n_fail++; $display("FAIL ws0_past_end: got v%b e%b want v1 e1", z_rsp_valid, z_rsp_err); end
        drive0(1'b1, 1'b1, 32'h13C, 32'h0000_007E, F3_B);
        @(negedge clk);
        n_checks++; if (z_rsp_valid !== 1'b1 || z_rsp_err !== 1'b0)
            begin n_fail++; $display("FAIL ws0_sb_last_word: got v%b e%b want v1 e0", z_rsp_valid, z_rsp_err); end
        drive0(1'b1, 1'b0, 32'h13C, 32'h0, F3_BU);
        @(negedge clk);
        n_checks++; if (z_rsp_valid !== 1'b1 || z_rsp_rdata !== 32'h0000_007E || z_rsp_err !== 1'b0)
            begin n_fail++; $display("FAIL ws0_lbu_last_word: got v%b e%b %h want v1 e0 7e", z_rsp_valid, z_rsp_err, z_rsp_rdata); end
        drive0(1'b0, 1'b0, 32'h0, 32'h0, F3_W);
        @(negedge clk);
        n_checks++; if (z_rsp_valid !== 1'b0 || z_rsp_rdata !== 32'h0000_007E)
            begin n_fail++; $display("FAIL ws0_idle_hold: got v%b %h want v0 7e", z_rsp_valid, z_rsp_rdata); end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_byte_lanes();
        test_errors();
        test_back_to_back();
        test_reset_midop();
        test_ws0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
